// File: rtl/mskaes_unmask_stream_if.sv
// mskaes_unmask_stream_if: ciphertext input and word-stream output bundle for the unmask stage
// Signals:
//   cipher_valid   one-cycle strobe: sh_ciphertext is valid
//   sh_ciphertext  shared ciphertext, bit i shares at [d*i +: d]
//   idle           stage empty, can accept the next cipher_valid
//   out_valid      out_data holds a valid word
//   out_ready      consumer accepts the word when out_valid & out_ready
//   out_data       unmasked ciphertext word
//   out_idx        word index 0..3 (0 = bits [127:96])
//   out_last       high on word index 3
//   overrun        sticky: cipher_valid arrived while not idle
// Modports: slave = the unmask stage, master = core plus consumer side.
interface mskaes_unmask_stream_if #(parameter int d = 2);
    logic               cipher_valid;
    logic [128*d-1:0]   sh_ciphertext;
    logic               idle;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               overrun;
    modport slave (
        input  cipher_valid, sh_ciphertext, out_ready,
        output idle, out_valid, out_data, out_idx, out_last, overrun
    );
    modport master (
        output cipher_valid, sh_ciphertext, out_ready,
        input  idle, out_valid, out_data, out_idx, out_last, overrun
    );
endinterface

// File: rtl/mskaes_unmask_stream.sv
// mskaes_unmask_stream: recombines d-share AES-128 ciphertext and streams it as four 32-bit words
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  mskaes_unmask_stream_if.slave: cipher_valid/sh_ciphertext in, idle/overrun status,
//        out_valid/out_ready/out_data/out_idx/out_last word stream
// The XOR over the shares of each bit in RECOMB is the only unmasking point; shares
// are wiped in the same step and the plaintext-domain register is wiped after the last word.
module mskaes_unmask_stream #(
    parameter int d = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mskaes_unmask_stream_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECOMB = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    logic [1:0]         state;
    logic [128*d-1:0]   share_reg;
    logic [127:0]       ct_reg;
    logic [127:0]       ct_next;
    logic [1:0]         idx;
    logic               overrun;
    logic               stream;
    always_comb begin
        ct_next = '0;
        for (int i = 0; i < 128; i++)
            ct_next[i] = ^share_reg[d*i +: d];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            share_reg <= '0;
            ct_reg    <= '0;
            idx       <= '0;
            overrun   <= 1'b0;
        end else begin
            if (bus.cipher_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (bus.cipher_valid) begin
                    share_reg <= bus.sh_ciphertext;
                    state     <= RECOMB;
                end
                RECOMB: begin
                    ct_reg    <= ct_next;
                    share_reg <= '0;
                    idx       <= '0;
                    state     <= STREAM;
                end
                STREAM: if (bus.out_ready) begin
                    if (idx == 2'd3) begin
                        ct_reg <= '0;
                        idx    <= '0;
                        state  <= IDLE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign stream        = state == STREAM;
    assign bus.idle      = state == IDLE;
    assign bus.out_valid = stream;
    // ~idx*32 selects word 0 from bits [127:96] down to word 3 from bits [31:0]
    assign bus.out_data  = stream ? ct_reg[{~idx, 5'd0} +: 32] : 32'd0;
    assign bus.out_idx   = idx;
    assign bus.out_last  = stream && idx == 2'd3;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_mskaes_unmask_stream.sv
// tb_mskaes_unmask_stream: scoreboard bench for the unmask stream stage (d=2 and d=3 instances)
module tb_mskaes_unmask_stream;
    localparam logic [127:0] CT1 = 128'h2e2b34ca59fa4c883b2c8aefd44be966;
    localparam logic [127:0] CT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] M1  = 128'h5a3c9f0172e4b8d6c10f3e7a9b2d4c85;
    localparam logic [127:0] M2  = 128'hf00dbeef13579bdf2468ace0cafe1234;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [34:0] q[$];
    always #5 clk = ~clk;
    mskaes_unmask_stream_if #(.d(2)) b2();
    mskaes_unmask_stream_if #(.d(3)) b3();
    mskaes_unmask_stream #(.d(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    mskaes_unmask_stream #(.d(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask
    // Monitor: every valid word must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (b2.out_valid) begin
                if (q.size() == 0) begin
                    chk("extra_word", {350'd0, 1'b1, b2.out_idx, b2.out_data}, 384'd0);
                end else begin
                    chk("word_data", b2.out_data, q[0][31:0]);
                    chk("word_idx", b2.out_idx, q[0][33:32]);
                    chk("word_last", b2.out_last, q[0][34]);
                    if (b2.out_ready) void'(q.pop_front());
                end
            end else begin
                chk("data_when_invalid", b2.out_data, 32'd0);
            end
        end
    end
    task automatic push_ct(input logic [127:0] ct);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) begin
            w = ct >> (96 - 32*k);
            q.push_back({k == 3, k[1:0], w[31:0]});
        end
    endtask
    task automatic send2(input logic [127:0] ct, input logic [127:0] m, input bit expect_out);
        logic [255:0] sh;
        for (int i = 0; i < 128; i++) begin
            sh[2*i]   = m[i];
            sh[2*i+1] = ct[i] ^ m[i];
        end
        b2.sh_ciphertext = sh;
        b2.cipher_valid  = 1'b1;
        if (expect_out) push_ct(ct);
        @(posedge clk);
        #1;
        b2.cipher_valid  = 1'b0;
        b2.sh_ciphertext = '0;
    endtask
    task automatic wait_idle(input bit rnd);
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
            if (b2.idle && q.size() == 0) done = 1'b1;
            else if (rnd) b2.out_ready = 1'($urandom_range(0, 1));
        end
        b2.out_ready = 1'b1;
        chk("drain_done", done, 1'b1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [383:0] sh3;
        bit hit;
        b2.cipher_valid = 1'b0; b2.sh_ciphertext = '0; b2.out_ready = 1'b0;
        b3.cipher_valid = 1'b0; b3.sh_ciphertext = '0; b3.out_ready = 1'b1;
        // 1: reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_idle", b2.idle, 1'b1);
        chk("rst_valid", b2.out_valid, 1'b0);
        chk("rst_data", b2.out_data, 32'd0);
        chk("rst_overrun", b2.overrun, 1'b0);
        chk("rst_idle_d3", b3.idle, 1'b1);
        // 2: latency with out_ready high
        b2.out_ready = 1'b1;
        send2(CT1, M1, 1'b1);
        chk("recomb_valid", b2.out_valid, 1'b0);
        chk("recomb_idle", b2.idle, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_valid", b2.out_valid, 1'b1);
        chk("stream_idx0", b2.out_idx, 2'd0);
        chk("stream_word0", b2.out_data, 32'h2e2b34ca);
        repeat (4) @(posedge clk);
        #1;
        chk("done_idle", b2.idle, 1'b1);
        chk("done_queue", q.size(), 0);
        // 3: same block under random backpressure
        send2(CT1, M2, 1'b1);
        wait_idle(1'b1);
        // 4: second cipher_valid during STREAM is dropped
        send2(CT2, M1, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send2(CT1, M2, 1'b0);
        chk("overrun_set", b2.overrun, 1'b1);
        wait_idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_second_block", b2.out_valid, 1'b0);
        chk("overrun_sticky", b2.overrun, 1'b1);
        // 5: reset after word 1 handshake
        send2(CT2, M2, 1'b1);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(posedge clk);
            if (q.size() == 2) hit = 1'b1;
        end
        chk("reach_word1", hit, 1'b1);
        #1;
        b2.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("abort_valid", b2.out_valid, 1'b0);
        chk("abort_idle", b2.idle, 1'b1);
        chk("abort_overrun", b2.overrun, 1'b0);
        b2.out_ready = 1'b1;
        send2(CT1, M1, 1'b1);
        @(posedge clk);
        #1;
        chk("restart_idx", b2.out_idx, 2'd0);
        chk("restart_word", b2.out_data, 32'h2e2b34ca);
        wait_idle(1'b0);
        // 6: d=3, masks all ones, ct=0
        for (int i = 0; i < 128; i++) begin
            sh3[3*i]   = 1'b1;
            sh3[3*i+1] = 1'b1;
            sh3[3*i+2] = 1'b0;
        end
        b3.sh_ciphertext = sh3;
        b3.cipher_valid  = 1'b1;
        @(posedge clk);
        #1;
        b3.cipher_valid  = 1'b0;
        b3.sh_ciphertext = '0;
        chk("d3_share_loaded", dut3.share_reg, sh3);
        @(posedge clk);
        #1;
        chk("d3_share_wiped", dut3.share_reg, 384'd0);
        for (int k = 0; k < 4; k++) begin
            chk("d3_valid", b3.out_valid, 1'b1);
            chk("d3_idx", b3.out_idx, k[1:0]);
            chk("d3_data", b3.out_data, 32'd0);
            chk("d3_last", b3.out_last, k == 3);
            @(posedge clk);
            #1;
        end
        chk("d3_idle", b3.idle, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
